// File: rtl/uart_tx_arbiter_pkg.sv
// rtl/uart_tx_arbiter_pkg.sv - shared UART definitions: arbiter states and frame timing math
package uart_tx_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  function automatic int calc_divisor(input int freq, input int baud);
    return freq / baud;
  endfunction

  // Two extra cycles cover the START strobe and the IDLE grant slot.
  function automatic int calc_frame_cycles(input int data_size, input int divisor);
    return (data_size + 2) * divisor + 2;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART serializer: start bit, DATA_SIZE bits LSB-first, stop bit
module uart_tx
  import uart_tx_arbiter_pkg::*;
#(
  parameter int FREQ      = 1_000_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [DATA_SIZE-1:0] data,
  output logic                 out
);

  localparam int DIVISOR    = calc_divisor(FREQ, BAUD);
  localparam int DIV_W      = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int FRAME_BITS = DATA_SIZE + 2;
  localparam int BIT_W      = $clog2(FRAME_BITS);

  logic                  r_active;
  logic [FRAME_BITS-1:0] r_shift;
  logic [DIV_W-1:0]      r_div;
  logic [BIT_W-1:0]      r_bit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= 1'b0;
      r_shift  <= '1;
      r_div    <= '0;
      r_bit    <= '0;
    end else if (!r_active) begin
      if (start) begin
        r_active <= 1'b1;
        r_shift  <= {1'b1, data, 1'b0};
        r_div    <= '0;
        r_bit    <= '0;
      end
    end else if (r_div == DIV_W'(DIVISOR - 1)) begin
      r_div   <= '0;
      r_shift <= {1'b1, r_shift[FRAME_BITS-1:1]};
      if (r_bit == BIT_W'(FRAME_BITS - 1)) begin
        r_active <= 1'b0;
      end else begin
        r_bit <= r_bit + BIT_W'(1);
      end
    end else begin
      r_div <= r_div + DIV_W'(1);
    end
  end

  assign out = r_active ? r_shift[0] : 1'b1;

endmodule

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among N_REQ requesters
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int FREQ      = 1_000_000_000,
  parameter int BAUD      = 115200,
  parameter int DATA_SIZE = 8,
  parameter int N_REQ     = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req,
  input  logic [N_REQ*DATA_SIZE-1:0]   data,
  output logic [N_REQ-1:0]             ack,
  output logic                         busy,
  output logic [2:0]                   owner,
  output logic                         out
);

  localparam int DIVISOR      = calc_divisor(FREQ, BAUD);
  localparam int FRAME_CYCLES = calc_frame_cycles(DATA_SIZE, DIVISOR);
  localparam int CNT_W        = $clog2(FRAME_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_CYCLES - 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [N_REQ-1:0]       r_ack;
  logic [2:0]             r_owner;
  logic [DATA_SIZE-1:0]   r_byte;

  logic                   w_any;
  logic [2:0]             w_win;
  logic [N_REQ-1:0]       w_grant;
  logic [DATA_SIZE-1:0]   w_sel;
  logic                   w_start;
  logic                   w_busy;
  logic                   w_tx_out;
  int                     w_idx;

  // Walk offsets 1..N_REQ from the last owner; first active request wins.
  always_comb begin
    w_any   = 1'b0;
    w_win   = r_owner;
    w_grant = '0;
    w_sel   = '0;
    w_idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_idx = int'(r_owner) + k;
      if (w_idx >= N_REQ) begin
        w_idx = w_idx - N_REQ;
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!w_any && (w_idx == i) && req[i]) begin
          w_any      = 1'b1;
          w_win      = 3'(i);
          w_grant[i] = 1'b1;
          w_sel      = data[i*DATA_SIZE +: DATA_SIZE];
        end
      end
    end
  end

  // Reset lands in WAIT so a frame cut short by reset drains before any grant.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_WAIT;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_any) w_next = ST_START;
      ST_START: w_next = ST_WAIT;
      ST_WAIT:  if (r_cnt == '0) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start = (r_state == ST_START);
    w_busy  = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt   <= CNT_LOAD;
      r_ack   <= '0;
      r_owner <= 3'(N_REQ - 1);
      r_byte  <= '0;
    end else begin
      r_ack <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_ack   <= w_grant;
            r_owner <= w_win;
            r_byte  <= w_sel;
          end
        end
        ST_START: r_cnt <= CNT_LOAD;
        ST_WAIT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  uart_tx #(
    .FREQ      (FREQ),
    .BAUD      (BAUD),
    .DATA_SIZE (DATA_SIZE)
  ) u_tx (
    .clk   (clk),
    .rst_n (reset),
    .start (w_start),
    .data  (r_byte),
    .out   (w_tx_out)
  );

  assign ack   = r_ack;
  assign busy  = w_busy;
  assign owner = r_owner;
  assign out   = w_tx_out | ~reset;

endmodule
